// File: rtl/branch_predict_unit.sv
// Branch resolution and 2-bit bimodal direction predictor with a single BHT.
// Also tracks resolved-branch and misprediction counts.
module branch_predict_unit #(
  parameter int unsigned BHT_ENTRIES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] if_pc_i,
  output logic        pred_taken_o,
  input  logic        ex_valid_i,
  input  logic        ex_is_branch_i,
  input  logic [2:0]  ex_funct3_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_target_i,
  input  logic        ex_pred_taken_i,
  output logic        BrUn_o,
  input  logic        BrEq_i,
  input  logic        BrLt_i,
  output logic        br_taken_o,
  output logic        mispredict_o,
  output logic [31:0] redirect_pc_o,
  output logic [31:0] br_cnt_o,
  output logic [31:0] mispred_cnt_o
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  ctr_e              r_bht [BHT_ENTRIES];
  logic [31:0]       r_br_cnt;
  logic [31:0]       r_mispred_cnt;

  logic [IDX_W-1:0]  w_if_idx;
  logic [IDX_W-1:0]  w_ex_idx;
  logic [1:0]        w_if_ctr;
  logic              w_legal;
  logic              w_cond;
  logic              w_resolve;
  logic              w_unused;

  function automatic ctr_e ctr_next(input ctr_e c, input logic up);
    ctr_e n;
    n = c;
    unique case (c)
      SNT: n = up ? WNT : SNT;
      WNT: n = up ? WT  : SNT;
      WT:  n = up ? ST  : WNT;
      ST:  n = up ? ST  : WT;
      default: n = WNT;
    endcase
    return n;
  endfunction

  assign w_if_idx     = if_pc_i[IDX_W+1:2];
  assign w_ex_idx     = ex_pc_i[IDX_W+1:2];
  assign w_if_ctr     = r_bht[w_if_idx];
  // Lookup reads the registered table directly: a same-cycle update is not bypassed.
  assign pred_taken_o = w_if_ctr[1];
  assign w_unused     = ^{if_pc_i[31:IDX_W+2], if_pc_i[1:0]};

  assign BrUn_o = (ex_funct3_i == 3'b110) || (ex_funct3_i == 3'b111);

  always_comb begin
    w_cond  = 1'b0;
    w_legal = 1'b1;
    unique case (ex_funct3_i)
      3'b000:         w_cond = BrEq_i;
      3'b001:         w_cond = !BrEq_i;
      3'b100, 3'b110: w_cond = BrLt_i;
      3'b101, 3'b111: w_cond = !BrLt_i;
      default:        w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_resolve     = ex_valid_i && ex_is_branch_i && w_legal;
    br_taken_o    = w_resolve && w_cond;
    mispredict_o  = w_resolve && (br_taken_o != ex_pred_taken_i);
    redirect_pc_o = '0;
    if (mispredict_o) begin
      redirect_pc_o = br_taken_o ? ex_target_i : (ex_pc_i + 32'd4);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
        r_bht[i] <= WNT;
      end
      r_br_cnt      <= '0;
      r_mispred_cnt <= '0;
    end else if (w_resolve) begin
      r_bht[w_ex_idx] <= ctr_next(r_bht[w_ex_idx], br_taken_o);
      if (r_br_cnt != '1) begin
        r_br_cnt <= r_br_cnt + 32'd1;
      end
      if (mispredict_o && (r_mispred_cnt != '1)) begin
        r_mispred_cnt <= r_mispred_cnt + 32'd1;
      end
    end
  end

  assign br_cnt_o      = r_br_cnt;
  assign mispred_cnt_o = r_mispred_cnt;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: a reference model queues expected
// outputs per cycle; a monitor compares them on the falling edge.
module tb_branch_predict_unit;

  localparam int N = 16;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic        ex_valid;
  logic        ex_is_branch;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_pred;
  logic        brun;
  logic        br_eq;
  logic        br_lt;
  logic        br_taken;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] br_cnt;
  logic [31:0] mispred_cnt;

  branch_predict_unit #(.BHT_ENTRIES(N)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .if_pc_i        (if_pc),
    .pred_taken_o   (pred_taken),
    .ex_valid_i     (ex_valid),
    .ex_is_branch_i (ex_is_branch),
    .ex_funct3_i    (ex_funct3),
    .ex_pc_i        (ex_pc),
    .ex_target_i    (ex_target),
    .ex_pred_taken_i(ex_pred),
    .BrUn_o         (brun),
    .BrEq_i         (br_eq),
    .BrLt_i         (br_lt),
    .br_taken_o     (br_taken),
    .mispredict_o   (mispredict),
    .redirect_pc_o  (redirect_pc),
    .br_cnt_o       (br_cnt),
    .mispred_cnt_o  (mispred_cnt)
  );

  typedef struct {
    string       tag;
    logic        pred;
    logic        brun;
    logic        taken;
    logic        mis;
    logic [31:0] redir;
    logic [31:0] brc;
    logic [31:0] misc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: counter strength 0..3 per entry, plain event counts.
  int          m_ctr [N];
  logic [31:0] m_brc;
  logic [31:0] m_misc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic cmp(input string name, input string tag, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s [%s]: got %h expected %h", name, tag, act, expv);
    end
  endtask

  // Monitor: combinational outputs are settled by the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp("pred_taken", e.tag, {31'd0, pred_taken}, {31'd0, e.pred});
        cmp("BrUn",       e.tag, {31'd0, brun},       {31'd0, e.brun});
        cmp("br_taken",   e.tag, {31'd0, br_taken},   {31'd0, e.taken});
        cmp("mispredict", e.tag, {31'd0, mispredict}, {31'd0, e.mis});
        cmp("redirect",   e.tag, redirect_pc,         e.redir);
        cmp("br_cnt",     e.tag, br_cnt,              e.brc);
        cmp("mispred_cnt",e.tag, mispred_cnt,         e.misc);
      end
    end
  end

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  task automatic step(input string tag, input logic r, input logic [31:0] ipc,
                      input logic v, input logic b, input logic [2:0] f3,
                      input logic [31:0] pc, input logic [31:0] tgt,
                      input logic pr, input logic eq, input logic lt, input bit chk);
    exp_t        e;
    logic        legal, resolve, cond, taken, mis;
    logic [31:0] pc4;
    @(posedge clk);
    #1;
    rst = r; if_pc = ipc; ex_valid = v; ex_is_branch = b; ex_funct3 = f3;
    ex_pc = pc; ex_target = tgt; ex_pred = pr; br_eq = eq; br_lt = lt;

    legal   = (f3 != 3'd2) && (f3 != 3'd3);
    resolve = v && b && legal;
    case (f3)
      3'd0:       cond = eq;
      3'd1:       cond = !eq;
      3'd4, 3'd6: cond = lt;
      3'd5, 3'd7: cond = !lt;
      default:    cond = 1'b0;
    endcase
    taken = resolve && cond;
    mis   = resolve && (taken != pr);
    pc4   = pc + 32'd4;

    e.tag   = tag;
    e.pred  = (m_ctr[idx_of(ipc)] >= 2);
    e.brun  = (f3 == 3'd6) || (f3 == 3'd7);
    e.taken = taken;
    e.mis   = mis;
    e.redir = mis ? (taken ? tgt : pc4) : 32'd0;
    e.brc   = m_brc;
    e.misc  = m_misc;
    if (chk) q.push_back(e);

    if (r) begin
      for (int i = 0; i < N; i++) m_ctr[i] = 1;
      m_brc  = 0;
      m_misc = 0;
    end else if (resolve) begin
      if (taken) m_ctr[idx_of(pc)] = (m_ctr[idx_of(pc)] == 3) ? 3 : m_ctr[idx_of(pc)] + 1;
      else       m_ctr[idx_of(pc)] = (m_ctr[idx_of(pc)] == 0) ? 0 : m_ctr[idx_of(pc)] - 1;
      if (m_brc != 32'hFFFF_FFFF) m_brc = m_brc + 1;
      if (mis && m_misc != 32'hFFFF_FFFF) m_misc = m_misc + 1;
    end
  endtask

  task automatic idle(input string tag, input logic [31:0] ipc);
    step(tag, 1'b0, ipc, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [31:0] rpc, ripc;
    int          wait_cyc;
    rst = 1'b1; if_pc = '0; ex_valid = 1'b0; ex_is_branch = 1'b0; ex_funct3 = '0;
    ex_pc = '0; ex_target = '0; ex_pred = 1'b0; br_eq = 1'b0; br_lt = 1'b0;
    for (int i = 0; i < N; i++) m_ctr[i] = 1;
    m_brc = 0; m_misc = 0;

    step("rst0", 1'b1, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rst1", 1'b1, 32'h100, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

    // BEQ taken while predicted not-taken, then look up the same PC
    step("beq", 1'b0, 32'h0, 1'b1, 1'b1, 3'd0, 32'h100, 32'h180, 1'b0, 1'b1, 1'b0, 1'b1);
    idle("beq_after", 32'h100);

    // BLTU taken three times (saturation) then once not-taken, same-PC lookup
    for (int k = 0; k < 3; k++)
      step("bltu_t", 1'b0, 32'h40, 1'b1, 1'b1, 3'd6, 32'h40, 32'h20, 1'b1, 1'b0, 1'b1, 1'b1);
    step("bltu_nt", 1'b0, 32'h40, 1'b1, 1'b1, 3'd6, 32'h40, 32'h20, 1'b1, 1'b0, 1'b0, 1'b1);
    idle("bltu_after", 32'h40);

    // BGE not-taken at the top of the address space wraps to 0
    step("bge_wrap", 1'b0, 32'h0, 1'b1, 1'b1, 3'd5, 32'hFFFF_FFFC, 32'h1000, 1'b1, 1'b0, 1'b1, 1'b1);

    // Same-cycle update and lookup: no bypass
    step("same_cyc", 1'b0, 32'h200, 1'b1, 1'b1, 3'd0, 32'h200, 32'h300, 1'b1, 1'b1, 1'b0, 1'b1);
    idle("same_after", 32'h200);

    // Non-resolving cases must not touch anything
    step("invalid", 1'b0, 32'h8, 1'b0, 1'b1, 3'd0, 32'h8, 32'h80, 1'b0, 1'b1, 1'b0, 1'b1);
    step("f3_010",  1'b0, 32'h8, 1'b1, 1'b1, 3'd2, 32'h8, 32'h80, 1'b0, 1'b1, 1'b0, 1'b1);
    step("f3_011",  1'b0, 32'h8, 1'b1, 1'b1, 3'd3, 32'h8, 32'h80, 1'b1, 1'b1, 1'b1, 1'b1);
    step("notbr",   1'b0, 32'h8, 1'b1, 1'b0, 3'd0, 32'h8, 32'h80, 1'b0, 1'b1, 1'b0, 1'b1);
    idle("nores_after", 32'h8);

    // Resolving branch during reset: outputs still combinational, no update
    step("br_in_rst", 1'b1, 32'h8, 1'b1, 1'b1, 3'd1, 32'h8, 32'h80, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) idle("post_rst_sweep", 32'(i) << 2);

    // Randomized traffic with a small PC pool so lookups and updates collide
    for (int k = 0; k < 800; k++) begin
      rpc  = ($urandom_range(0, 3) == 0) ? $urandom() : (32'($urandom_range(0, 23)) << 2);
      ripc = ($urandom_range(0, 3) == 0) ? $urandom() : (32'($urandom_range(0, 23)) << 2);
      step("random", ($urandom_range(0, 59) == 0), ripc,
           ($urandom_range(0, 7) != 0), ($urandom_range(0, 5) != 0),
           3'($urandom_range(0, 7)), rpc, $urandom(),
           1'($urandom()), 1'($urandom()), 1'($urandom()), 1'b1);
    end

    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have parameter BHT_ENTRIES, default 16, giving the number of 2-bit history counters (power of 2, 4..256).
REQ-002 SHALL have clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have rst_i, input, 1, the reset, which is synchronous and active-high.
REQ-004 SHALL have if_pc_i, input, 32, the fetch-stage PC used for prediction lookup.
REQ-005 SHALL have pred_taken_o, output, 1, the fetch-stage direction prediction for if_pc_i.
REQ-006 SHALL have ex_valid_i, input, 1, high when the EX-stage instruction is valid (not a bubble or flushed).
REQ-007 SHALL have ex_is_branch_i, input, 1, high when the EX-stage instruction is a conditional branch (opcode 1100011).
REQ-008 SHALL have ex_funct3_i, input, 3, the branch funct3 of the EX instruction.
REQ-009 SHALL have ex_pc_i, input, 32, the PC of the EX instruction.
REQ-010 SHALL have ex_target_i, input, 32, the computed branch target (PC + B-immediate).
REQ-011 SHALL have ex_pred_taken_i, input, 1, the prediction carried down the pipe with the EX instruction.
REQ-012 SHALL have BrUn_o, output, 1, the unsigned-compare select driven to the branch comparator.
REQ-013 SHALL have BrEq_i and BrLt_i, inputs, 1 each, the comparator results for the EX instruction.
REQ-014 SHALL have br_taken_o, output, 1, the resolved branch direction.
REQ-015 SHALL have mispredict_o, output, 1, a flush request for IF/ID.
REQ-016 SHALL have redirect_pc_o, output, 32, the correct next PC when mispredict_o=1, else 0.
REQ-017 SHALL have br_cnt_o and mispred_cnt_o, outputs, 32 each, performance counters.

Function
REQ-018 SHALL drive BrUn_o = 1 when ex_funct3_i is 110 or 111, else 0 (combinational).
REQ-019 SHALL resolve taken combinationally for the current EX instruction: 000 BrEq; 001 !BrEq; 100 BrLt; 101 !BrLt; 110 BrLt; 111 !BrLt.
REQ-020 SHALL treat funct3 010/011 as not-taken, with no counter or statistics update and mispredict_o=0.
REQ-021 SHALL define a branch as resolving when ex_valid_i & ex_is_branch_i & legal funct3; otherwise br_taken_o=0 and mispredict_o=0.
REQ-022 SHALL index the table by PC[log2(BHT_ENTRIES)+1:2], for both lookup and update.
REQ-023 SHALL give each counter the states SNT=00, WNT=01, WT=10, ST=11.
REQ-024 SHALL, on a resolving taken branch, increment the indexed counter, saturating at ST.
REQ-025 SHALL, on a resolving not-taken branch, decrement the indexed counter, saturating at SNT.
REQ-026 SHALL drive pred_taken_o = MSB of the counter indexed by if_pc_i, combinationally, with zero-cycle lookup latency.
REQ-027 SHALL have no lookup bypass: when the update index equals the lookup index in the same cycle, pred_taken_o shows the pre-update value; the new value is visible the next cycle.
REQ-028 SHALL assert mispredict_o in the same cycle when a resolving branch has taken != ex_pred_taken_i.
REQ-029 SHALL set redirect_pc_o to ex_target_i when actually taken, or to ex_pc_i+4 (mod 2^32) when actually not taken.
REQ-030 SHALL increment br_cnt_o by 1 per resolving branch, saturating at 0xFFFFFFFF.
REQ-031 SHALL increment mispred_cnt_o by 1 per mispredict, saturating at 0xFFFFFFFF.

Reset
REQ-032 SHALL, while rst_i=1 at a clock edge, set all counters to WNT (01) and both statistics counters to 0.
REQ-033 SHALL suppress table and statistics updates in any cycle where rst_i=1, even if a branch resolves.
REQ-034 SHALL keep combinational outputs (BrUn_o, br_taken_o, mispredict_o, redirect_pc_o) as functions of inputs during reset; pred_taken_o=0 after reset.

Verification
REQ-035 Reset, then BEQ at pc 0x100 with BrEq=1 and pred=0 -> mispredict_o=1, redirect=target; next cycle if_pc 0x100 gives pred_taken_o=1, br_cnt=1, mispred_cnt=1.
REQ-036 Three taken BLTU at pc 0x40 -> BrUn_o=1; counter 01->10->11->11 (saturates); then one not-taken -> 10, pred still 1.
REQ-037 BGE at pc 0xFFFFFFFC, not taken, pred=1 -> redirect_pc_o=0x00000000 (wrap-around), mispredict_o=1.
REQ-038 Same-cycle update and lookup of pc 0x200 (counter 01, taken) -> pred_taken_o=0 that cycle, 1 the next.
REQ-039 ex_valid_i=0, or funct3=010, with BrEq=1 -> br_taken_o=0, mispredict_o=0, no counter or statistics change.
REQ-040 Branch resolves with rst_i=1 -> no update; after reset all entries read WNT and statistics counters read 0.
